// File: rtl/monitor_overlay_ctrl_if.sv
// CPU-side bus bundle for the monitor overlay controller.
// The master drives the 6502 bus cycle and NMI; the slave returns the
// monitor/RAM decode.
interface monitor_overlay_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        cpu_sync;
  logic        bus_strobe;
  logic        nmi_n;
  logic        mon_sel;
  logic [7:0]  mon_addr;
  logic        mon_we;
  logic        ram_cs;
  logic        ram_we;

  modport master (
    output cpu_addr, cpu_rw, cpu_sync, bus_strobe, nmi_n,
    input  mon_sel, mon_addr, mon_we, ram_cs, ram_we
  );

  modport slave (
    input  cpu_addr, cpu_rw, cpu_sync, bus_strobe, nmi_n,
    output mon_sel, mon_addr, mon_we, ram_cs, ram_we
  );
endinterface

// File: rtl/monitor_overlay_ctrl.sv
// Monitor-ROM overlay sequencer.
// A debug NMI arms the overlay. The vector fetch is served from the monitor
// window. The vector-high read switches the whole OVL_PAGE to the monitor.
// A sync fetch outside that page (the post-RTI opcode) returns the bus to RAM.
// Decode is combinational from the registered state; every transition is registered.
module monitor_overlay_ctrl #(
  parameter logic [7:0]  OVL_PAGE    = 8'hFF,
  parameter logic [15:0] VEC_LO      = 16'hFFFA,
  parameter logic [7:0]  ARM_TIMEOUT = 8'd64   // legal range 1..255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  monitor_overlay_ctrl_if.slave   bus,
  output logic [1:0]              state_o,
  output logic                    arm_timeout_o,
  output logic [7:0]              ovl_entries_o
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_OVERLAY = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [15:0] VEC_HI  = VEC_LO + 16'd1;
  localparam logic [7:0]  TO_LAST = ARM_TIMEOUT - 8'd1;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] ovl_entries_q;
  logic       arm_timeout_q;
  logic       nmi_q;
  // High for the first clock after reset. This masks the fall that the
  // reset value of nmi_q would otherwise fake when nmi_n is held low
  // through reset.
  logic       rst_q;

  logic       nmi_fall;
  logic       vec_hi_rd;
  logic       in_page;
  logic       mon_sel_c;

  assign nmi_fall  = nmi_q & ~bus.nmi_n & ~rst_q;
  assign in_page   = (bus.cpu_addr[15:8] == OVL_PAGE);
  assign vec_hi_rd = bus.bus_strobe & bus.cpu_rw & (bus.cpu_addr == VEC_HI);

  // Zero-latency decode of the live bus cycle against the current state.
  always_comb begin
    mon_sel_c = 1'b0;
    case (state_q)
      ST_ARMED:   mon_sel_c = bus.cpu_rw & ((bus.cpu_addr == VEC_LO) | (bus.cpu_addr == VEC_HI));
      ST_OVERLAY: mon_sel_c = in_page;
      default:    mon_sel_c = 1'b0;
    endcase
  end

  assign bus.mon_sel  = mon_sel_c;
  assign bus.mon_addr = mon_sel_c ? bus.cpu_addr[7:0] : 8'h00;
  assign bus.mon_we   = bus.bus_strobe & ~bus.cpu_rw & mon_sel_c;
  assign bus.ram_cs   = ~mon_sel_c;
  assign bus.ram_we   = ~bus.cpu_rw & ~mon_sel_c;

  assign state_o       = state_q;
  assign arm_timeout_o = arm_timeout_q;
  assign ovl_entries_o = ovl_entries_q;

  // Overlay FSM with the NMI edge history, arm timer and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_NORMAL;
      cnt_q         <= 8'd0;
      ovl_entries_q <= 8'd0;
      arm_timeout_q <= 1'b0;
      nmi_q         <= 1'b1;
      rst_q         <= 1'b1;
    end else begin
      nmi_q         <= bus.nmi_n;
      rst_q         <= 1'b0;
      arm_timeout_q <= 1'b0;
      case (state_q)
        ST_NORMAL: begin
          // A strobe on the same clock as the fall is not counted.
          if (nmi_fall) begin
            state_q <= ST_ARMED;
            cnt_q   <= 8'd0;
          end
        end
        ST_ARMED: begin
          // The vector-high read beats both a re-arm and expiry on the same strobe.
          if (vec_hi_rd) begin
            state_q       <= ST_OVERLAY;
            ovl_entries_q <= ovl_entries_q + 8'd1;
          end else if (nmi_fall) begin
            cnt_q <= 8'd0;
          end else if (bus.bus_strobe) begin
            if (cnt_q == TO_LAST) begin
              state_q       <= ST_NORMAL;
              arm_timeout_q <= 1'b1;
              cnt_q         <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_OVERLAY: begin
          // NMI edges are ignored here. Only an opcode fetch off the page ends the overlay.
          if (bus.bus_strobe & bus.cpu_sync & ~in_page)
            state_q <= ST_NORMAL;
        end
        default: state_q <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_overlay_ctrl.sv
// Bench for monitor_overlay_ctrl. The directed scenarios check fixed expected
// values. The random phase compares the DUT against a cycle-level behavioural
// model of the overlay rules.
module tb_monitor_overlay_ctrl;
  localparam logic [7:0]  PAGE = 8'hFF;
  localparam logic [15:0] VLO  = 16'hFFFA;
  localparam logic [15:0] VHI  = 16'hFFFB;
  localparam int          TMO  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_o;
  logic       arm_timeout_o;
  logic [7:0] ovl_entries_o;

  int checks = 0;
  int errors = 0;

  monitor_overlay_ctrl_if bus();

  monitor_overlay_ctrl #(.OVL_PAGE(PAGE), .VEC_LO(VLO), .ARM_TIMEOUT(8'(TMO))) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .state_o      (state_o),
    .arm_timeout_o(arm_timeout_o),
    .ovl_entries_o(ovl_entries_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state: 0 normal, 1 armed, 2 overlay.
  int m_state = 0, m_cnt = 0, m_ent = 0;
  bit m_to = 0, m_line_prev = 1, m_rst_prev = 1;

  function automatic bit m_sel(logic [15:0] a, logic rw);
    if (m_state == 1) return rw && (a == VLO || a == VHI);
    if (m_state == 2) return a[15:8] == PAGE;
    return 0;
  endfunction

  // Apply one clock of the rules to the model using the inputs present at the edge.
  task automatic model_step();
    bit fall;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_ent = 0; m_to = 0;
      m_line_prev = 1; m_rst_prev = 1;
      return;
    end
    fall = m_line_prev && !bus.nmi_n && !m_rst_prev;
    m_to = 0;
    if (m_state == 0) begin
      if (fall) begin m_state = 1; m_cnt = 0; end
    end else if (m_state == 1) begin
      if (bus.bus_strobe && bus.cpu_rw && bus.cpu_addr == VHI) begin
        m_state = 2; m_ent = (m_ent + 1) % 256;
      end else if (fall) m_cnt = 0;
      else if (bus.bus_strobe) begin
        m_cnt++;
        if (m_cnt >= TMO) begin m_state = 0; m_to = 1; m_cnt = 0; end
      end
    end else begin
      if (bus.bus_strobe && bus.cpu_sync && bus.cpu_addr[15:8] != PAGE) m_state = 0;
    end
    m_line_prev = bus.nmi_n;
    m_rst_prev = 0;
  endtask

  task automatic drive(logic [15:0] a, logic rw, logic sy, logic stb, logic nmi, logic r);
    @(negedge clk);
    bus.cpu_addr = a; bus.cpu_rw = rw; bus.cpu_sync = sy;
    bus.bus_strobe = stb; bus.nmi_n = nmi; rst = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(16'hFF10, 1, 0, 0, 1, 1); tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++; if (ovl_entries_o !== 8'd0) begin errors++; $display("FAIL reset_entries got %0d exp 0", ovl_entries_o); end
    checks++; if (arm_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", arm_timeout_o); end
    checks++; if (bus.mon_sel !== 1'b0) begin errors++; $display("FAIL reset_monsel got %0b exp 0", bus.mon_sel); end
    drive(16'h0000, 1, 0, 0, 1, 0); tick();
  endtask

  task automatic test_entry();
    drive(16'h0000, 1, 0, 0, 0, 0); tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL entry_armed got %0d exp 1", state_o); end
    drive(VLO, 1, 0, 1, 0, 0);
    checks++; if (bus.mon_sel !== 1'b1 || bus.mon_addr !== 8'hFA) begin errors++; $display("FAIL entry_veclo sel %0b addr %h exp 1 FA", bus.mon_sel, bus.mon_addr); end
    tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL entry_still_armed got %0d exp 1", state_o); end
    drive(VHI, 1, 0, 1, 0, 0);
    checks++; if (bus.mon_sel !== 1'b1) begin errors++; $display("FAIL entry_vechi sel %0b exp 1", bus.mon_sel); end
    tick();
    checks++; if (state_o !== 2'd2 || ovl_entries_o !== 8'd1) begin errors++; $display("FAIL entry_overlay state %0d ent %0d exp 2 1", state_o, ovl_entries_o); end
  endtask

  task automatic test_overlay_access();
    drive(16'hFF10, 1, 0, 1, 0, 0);
    checks++; if (bus.mon_sel !== 1'b1 || bus.mon_addr !== 8'h10 || bus.ram_cs !== 1'b0) begin errors++; $display("FAIL ovl_read sel %0b addr %h cs %0b exp 1 10 0", bus.mon_sel, bus.mon_addr, bus.ram_cs); end
    tick();
    drive(16'h01FD, 0, 0, 1, 0, 0);
    checks++; if (bus.ram_we !== 1'b1 || bus.mon_sel !== 1'b0 || bus.mon_we !== 1'b0) begin errors++; $display("FAIL ovl_stack we %0b sel %0b mwe %0b exp 1 0 0", bus.ram_we, bus.mon_sel, bus.mon_we); end
    tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL ovl_stack_state got %0d exp 2", state_o); end
    drive(16'hFF20, 0, 0, 1, 0, 0);
    checks++; if (bus.mon_we !== 1'b1 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL ovl_write mwe %0b rwe %0b exp 1 0", bus.mon_we, bus.ram_we); end
    tick();
    drive(16'h0400, 1, 1, 1, 0, 0);
    checks++; if (bus.ram_cs !== 1'b1 || bus.mon_sel !== 1'b0) begin errors++; $display("FAIL ovl_exit_fetch cs %0b sel %0b exp 1 0", bus.ram_cs, bus.mon_sel); end
    tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL ovl_exit_state got %0d exp 0", state_o); end
  endtask

  task automatic arm();
    drive(16'h0000, 1, 0, 0, 1, 0); tick();
    drive(16'h0000, 1, 0, 0, 0, 0); tick();
  endtask

  task automatic test_timeout();
    arm();
    for (int i = 0; i < TMO; i++) begin
      drive(16'h0300, 1, 0, 1, 0, 0); tick();
      if (i < TMO - 1) begin
        checks++; if (state_o !== 2'd1 || arm_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_early%0d state %0d to %0b exp 1 0", i, state_o, arm_timeout_o); end
      end
    end
    checks++; if (state_o !== 2'd0 || arm_timeout_o !== 1'b1 || ovl_entries_o !== 8'd1) begin errors++; $display("FAIL tmo_expire state %0d to %0b ent %0d exp 0 1 1", state_o, arm_timeout_o, ovl_entries_o); end
    drive(16'h0300, 1, 0, 0, 0, 0); tick();
    checks++; if (arm_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width got %0b exp 0", arm_timeout_o); end
  endtask

  task automatic test_vector_wins();
    arm();
    for (int i = 0; i < TMO - 1; i++) begin drive(16'h0300, 1, 0, 1, 0, 0); tick(); end
    drive(VHI, 1, 0, 1, 0, 0); tick();
    checks++; if (state_o !== 2'd2 || arm_timeout_o !== 1'b0 || ovl_entries_o !== 8'd2) begin errors++; $display("FAIL vec_wins state %0d to %0b ent %0d exp 2 0 2", state_o, arm_timeout_o, ovl_entries_o); end
  endtask

  task automatic test_nmi_in_overlay();
    drive(16'hFF00, 1, 0, 0, 1, 0); tick();
    drive(16'hFF00, 1, 0, 0, 0, 0); tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL nmi_ovl_state got %0d exp 2", state_o); end
    drive(16'h0400, 1, 1, 1, 0, 0); tick();
    drive(16'h0401, 1, 0, 0, 0, 0); tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL nmi_ovl_not_queued got %0d exp 0", state_o); end
  endtask

  task automatic test_rst_in_overlay();
    arm();
    drive(VHI, 1, 0, 1, 0, 0); tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL rst_setup got %0d exp 2", state_o); end
    drive(16'hFF10, 1, 0, 0, 0, 1); tick();
    checks++; if (state_o !== 2'd0 || ovl_entries_o !== 8'd0) begin errors++; $display("FAIL rst_ovl state %0d ent %0d exp 0 0", state_o, ovl_entries_o); end
    drive(16'hFF10, 1, 0, 1, 0, 0);
    checks++; if (bus.mon_sel !== 1'b0) begin errors++; $display("FAIL rst_decode sel %0b exp 0", bus.mon_sel); end
    tick();
    for (int i = 0; i < 3; i++) begin drive(16'h0200, 1, 0, 0, 0, 0); tick(); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_no_false_edge got %0d exp 0", state_o); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic rw, sy, stb, nmi, r;
    bit exp_sel;
    nmi = 1'b1;
    drive(16'h0000, 1, 0, 0, 1, 1); tick();
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 6))
        0: a = VLO;
        1: a = VHI;
        2: a = {PAGE, 8'($urandom)};
        3: a = 16'h0400;
        4: a = {8'h01, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      rw  = ($urandom_range(0, 3) != 0);
      sy  = $urandom_range(0, 1) == 1;
      stb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) nmi = ~nmi;
      r   = ($urandom_range(0, 79) == 0);
      drive(a, rw, sy, stb, nmi, r);
      exp_sel = m_sel(a, rw);
      checks++;
      if (bus.mon_sel !== exp_sel || bus.mon_addr !== (exp_sel ? a[7:0] : 8'h00) ||
          bus.mon_we !== (stb & ~rw & exp_sel) || bus.ram_cs !== ~exp_sel || bus.ram_we !== (~rw & ~exp_sel)) begin
        errors++;
        $display("FAIL rand_decode n=%0d addr %h sel %0b maddr %h mwe %0b cs %0b rwe %0b exp_sel %0b", n, a, bus.mon_sel, bus.mon_addr, bus.mon_we, bus.ram_cs, bus.ram_we, exp_sel);
      end
      tick();
      checks++;
      if (state_o !== 2'(m_state) || arm_timeout_o !== m_to || ovl_entries_o !== 8'(m_ent)) begin
        errors++;
        $display("FAIL rand_state n=%0d state %0d to %0b ent %0d exp %0d %0b %0d", n, state_o, arm_timeout_o, ovl_entries_o, m_state, m_to, m_ent);
      end
    end
  endtask

  initial begin
    bus.cpu_addr = 16'h0000; bus.cpu_rw = 1'b1; bus.cpu_sync = 1'b0;
    bus.bus_strobe = 1'b0; bus.nmi_n = 1'b1; rst = 1'b1;
    test_reset();
    test_entry();
    test_overlay_access();
    test_timeout();
    test_vector_wins();
    test_nmi_in_overlay();
    test_rst_in_overlay();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
